// File: rtl/conv_1x1_weight_bank.sv
// Weight bank for the 1x1 convolution layers: fills DEPTH weights from the loader
// stream, then serves them to the MAC array either once (consume) or cyclically (replay).
module conv_1x1_weight_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  load_weights,
  input  logic                  replay_en,
  output logic [DATA_WIDTH-1:0] out_buffer_weight,
  output logic                  valid_out,
  output logic                  last_out,
  output logic                  weights_ready,
  output logic                  overflow
);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

  // Pointers wrap at DEPTH-1, not at 2^ADDR_WIDTH, so odd depths work.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1'b1);

  state_t                  state_r;
  state_t                  state_s;
  logic [DATA_WIDTH-1:0]   in_q_r;
  logic                    vin_q_r;
  logic [ADDR_WIDTH-1:0]   wr_ptr_r;
  logic [ADDR_WIDTH-1:0]   rd_ptr_r;
  logic                    wr_en_s;
  logic                    rd_en_s;
  logic                    ovf_s;
  logic                    wr_last_s;
  logic                    rd_last_s;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Input stage: register the loader stream once before it reaches the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      vin_q_r <= 1'b0;
      in_q_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      vin_q_r <= valid_in;
      in_q_r  <= in;
    end
  end

  // Decode: FILL only writes, READY only reads; a write while READY is an overflow.
  always_comb begin
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    ovf_s     = 1'b0;
    wr_last_s = (wr_ptr_r == LAST_IDX);
    rd_last_s = (rd_ptr_r == LAST_IDX);
    state_s   = state_r;
    case (state_r)
      FILL: begin
        wr_en_s = vin_q_r;
        if (vin_q_r && wr_last_s) begin
          state_s = READY;
        end else begin
          state_s = FILL;
        end
      end
      READY: begin
        rd_en_s = load_weights;
        ovf_s   = vin_q_r;
        // replay_en only matters on the wrap read
        if (load_weights && rd_last_s && !replay_en) begin
          state_s = FILL;
        end else begin
          state_s = READY;
        end
      end
      default: begin
        state_s = FILL;
      end
    endcase
  end

  // Weight RAM write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r] <= in_q_r;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= FILL;
      wr_ptr_r          <= ZERO_IDX;
      rd_ptr_r          <= ZERO_IDX;
      out_buffer_weight <= {DATA_WIDTH{1'b0}};
      valid_out         <= 1'b0;
      last_out          <= 1'b0;
      weights_ready     <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      state_r       <= state_s;
      weights_ready <= (state_s == READY);
      if (ovf_s) begin
        overflow <= 1'b1;
      end
      if (wr_en_s) begin
        wr_ptr_r <= wr_last_s ? ZERO_IDX : (wr_ptr_r + ONE_IDX);
      end
      if (rd_en_s) begin
        out_buffer_weight <= mem[rd_ptr_r];
        rd_ptr_r          <= rd_last_s ? ZERO_IDX : (rd_ptr_r + ONE_IDX);
        valid_out         <= 1'b1;
        last_out          <= rd_last_s;
      end else begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_1x1_weight_bank.sv
// Directed bench for conv_1x1_weight_bank: a DEPTH=4 bank for the main scenarios
// and a DEPTH=3 bank for non-power-of-two wrapping.
module tb_conv_1x1_weight_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, load_weights, replay_en;
  logic [31:0] in;
  logic [31:0] out_buffer_weight;
  logic        valid_out, last_out, weights_ready, overflow;

  logic        v3, ld3, rp3;
  logic [31:0] in3;
  logic [31:0] o3;
  logic        vo3, lo3, wr3, ov3;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] wv [4];

  always #5 clk = ~clk;

  conv_1x1_weight_bank #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2)) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in(in),
    .load_weights(load_weights), .replay_en(replay_en),
    .out_buffer_weight(out_buffer_weight), .valid_out(valid_out),
    .last_out(last_out), .weights_ready(weights_ready), .overflow(overflow)
  );

  conv_1x1_weight_bank #(.DATA_WIDTH(32), .DEPTH(3), .ADDR_WIDTH(2)) u_dut3 (
    .clk(clk), .reset(reset), .valid_in(v3), .in(in3),
    .load_weights(ld3), .replay_en(rp3),
    .out_buffer_weight(o3), .valid_out(vo3),
    .last_out(lo3), .weights_ready(wr3), .overflow(ov3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_bank();
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      in       = wv[i];
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 10 && !weights_ready; t++) begin
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; in = 32'h0; load_weights = 1'b0; replay_en = 1'b0;
    v3 = 1'b0; in3 = 32'h0; ld3 = 1'b0; rp3 = 1'b0;
    step(); step();
    checks++;
    if ({out_buffer_weight, valid_out, last_out, weights_ready, overflow} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%b%b%b%b exp 0", out_buffer_weight,
               valid_out, last_out, weights_ready, overflow);
    end
    reset = 1'b0;
    step();
    checks++;
    if (weights_ready !== 1'b0 || wr3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b/%b exp 0/0", weights_ready, wr3);
    end
  endtask

  // Fill with load_weights held: nothing may be read during FILL.
  task automatic test_early_fill();
    wv[0] = 32'h11; wv[1] = 32'h22; wv[2] = 32'h33; wv[3] = 32'h44;
    load_weights = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid_in = (i < 4);
      in       = (i < 4) ? wv[i % 4] : 32'h0;
      step();
      checks++;
      if (valid_out !== 1'b0 || out_buffer_weight !== 32'h0) begin
        errors++;
        $display("FAIL early_load step %0d got %b/%h exp 0/00000000", i, valid_out, out_buffer_weight);
      end
      checks++;
      if (weights_ready !== (i == 4)) begin
        errors++;
        $display("FAIL ready_latency step %0d got %b exp %b", i, weights_ready, (i == 4));
      end
    end
    valid_in     = 1'b0;
    load_weights = 1'b0;
  endtask

  task automatic test_drain();
    replay_en    = 1'b0;
    load_weights = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_buffer_weight !== wv[i] || valid_out !== 1'b1 || last_out !== (i == 3)) begin
        errors++;
        $display("FAIL drain %0d got %h v%b l%b exp %h v1 l%b", i, out_buffer_weight,
                 valid_out, last_out, wv[i], (i == 3));
      end
    end
    checks++;
    if (weights_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_ready_drop got %b exp 0", weights_ready);
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || out_buffer_weight !== 32'h44) begin
      errors++;
      $display("FAIL load_after_wrap got %b/%h exp 0/00000044", valid_out, out_buffer_weight);
    end
    load_weights = 1'b0;
  endtask

  task automatic test_replay();
    int lasts;
    lasts = 0;
    fill_bank();
    wait_ready();
    checks++;
    if (weights_ready !== 1'b1) begin
      errors++;
      $display("FAIL replay_fill_ready got %b exp 1", weights_ready);
    end
    replay_en    = 1'b1;
    load_weights = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (last_out) lasts++;
      checks++;
      if (out_buffer_weight !== wv[i % 4] || valid_out !== 1'b1 || weights_ready !== 1'b1) begin
        errors++;
        $display("FAIL replay %0d got %h v%b r%b exp %h v1 r1", i, out_buffer_weight,
                 valid_out, weights_ready, wv[i % 4]);
      end
    end
    load_weights = 1'b0;
    checks++;
    if (lasts !== 3) begin
      errors++;
      $display("FAIL replay_last_count got %0d exp 3", lasts);
    end
  endtask

  task automatic test_overflow();
    valid_in = 1'b1; in = 32'h55;
    step();
    valid_in = 1'b0;
    step();
    checks++;
    if (overflow !== 1'b1 || weights_ready !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got o%b r%b exp o1 r1", overflow, weights_ready);
    end
    replay_en    = 1'b0;
    load_weights = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_buffer_weight !== wv[i] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL overflow_data %0d got %h exp %h", i, out_buffer_weight, wv[i]);
      end
    end
    load_weights = 1'b0;
    checks++;
    if (overflow !== 1'b1 || weights_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sticky got o%b r%b exp o1 r0", overflow, weights_ready);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] vpat;
    logic [7:0] lpat;
    int n, loads, pulses;
    vpat = 8'b1100_1101;
    lpat = 8'b0101_1001;
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL gapped_ovf_clear got %b exp 0", overflow);
    end
    wv[0] = 32'h60; wv[1] = 32'h61; wv[2] = 32'h62; wv[3] = 32'h63;
    n = 0;
    for (int c = 0; c < 16 && n < 4; c++) begin
      valid_in = vpat[c % 8];
      in       = wv[n];
      if (valid_in) n++;
      step();
    end
    valid_in = 1'b0;
    wait_ready();
    checks++;
    if (weights_ready !== 1'b1) begin
      errors++;
      $display("FAIL gapped_ready got %b exp 1", weights_ready);
    end
    loads = 0; pulses = 0;
    for (int c = 0; c < 20 && loads < 4; c++) begin
      load_weights = lpat[c % 8];
      if (load_weights) loads++;
      step();
      if (valid_out) begin
        checks++;
        if (out_buffer_weight !== wv[pulses % 4]) begin
          errors++;
          $display("FAIL gapped_data %0d got %h exp %h", pulses, out_buffer_weight, wv[pulses % 4]);
        end
        pulses++;
      end
    end
    load_weights = 1'b0;
    step();
    checks++;
    if (pulses !== 4 || loads !== 4 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL gapped_counts got pulses %0d loads %0d exp 4 4", pulses, loads);
    end
  endtask

  task automatic test_reset_mid_read();
    wv[0] = 32'h70; wv[1] = 32'h71; wv[2] = 32'h72; wv[3] = 32'h73;
    fill_bank();
    wait_ready();
    load_weights = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_buffer_weight !== wv[i]) begin
        errors++;
        $display("FAIL midread_data %0d got %h exp %h", i, out_buffer_weight, wv[i]);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if ({out_buffer_weight, valid_out, last_out, weights_ready, overflow} !== 36'h0) begin
      errors++;
      $display("FAIL midread_reset got %h/%b%b%b%b exp 0", out_buffer_weight,
               valid_out, last_out, weights_ready, overflow);
    end
    reset = 1'b0; load_weights = 1'b0;
    wv[0] = 32'hA0; wv[1] = 32'hA1; wv[2] = 32'hA2; wv[3] = 32'hA3;
    fill_bank();
    wait_ready();
    load_weights = 1'b1;
    step();
    load_weights = 1'b0;
    checks++;
    if (out_buffer_weight !== 32'hA0 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL refill_first got %h v%b exp 000000a0 v1", out_buffer_weight, valid_out);
    end
  endtask

  task automatic test_npot();
    logic [31:0] e3 [3];
    e3[0] = 32'hB0; e3[1] = 32'hB1; e3[2] = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      v3 = 1'b1; in3 = e3[i];
      step();
    end
    v3 = 1'b0;
    step();
    checks++;
    if (wr3 !== 1'b1) begin
      errors++;
      $display("FAIL npot_ready got %b exp 1", wr3);
    end
    rp3 = 1'b1; ld3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (o3 !== e3[i % 3] || vo3 !== 1'b1 || lo3 !== ((i % 3) == 2)) begin
        errors++;
        $display("FAIL npot_replay %0d got %h v%b l%b exp %h v1 l%b", i, o3, vo3, lo3,
                 e3[i % 3], ((i % 3) == 2));
      end
    end
    ld3 = 1'b0;
    checks++;
    if (wr3 !== 1'b1 || ov3 !== 1'b0) begin
      errors++;
      $display("FAIL npot_state got r%b o%b exp r1 o0", wr3, ov3);
    end
  endtask

  initial begin
    test_reset();
    test_early_fill();
    test_drain();
    test_replay();
    test_overflow();
    test_gapped();
    test_reset_mid_read();
    test_npot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end

endmodule

// File: doc/conv_1x1_weight_bank.md
# conv_1x1_weight_bank

Parametrised weight store for the 1x1 convolution layers. It replaces the per-layer input-DFF plus vendor-FIFO weight buffers with one inferred-RAM bank that holds `DEPTH` weights. The bank supports two modes. In consume mode it is drained once and then refilled. In replay mode it is read cyclically any number of times, so one kernel set serves every pixel of a feature map. It sits between the weight loader stream and the 1x1 multiply-accumulate array.

## Interface
- `DATA_WIDTH`, 32, width of one weight word.
- `DEPTH`, 64, number of weights held; must be ≥ 2.
- `ADDR_WIDTH`, 6, pointer width; must satisfy 2^`ADDR_WIDTH` ≥ `DEPTH`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  `in` carries a weight this cycle.
- `in`  in  `DATA_WIDTH`  incoming weight word.
- `load_weights`  in  1  read request for the next weight.
- `replay_en`  in  1  1 = replay mode, 0 = consume mode; sampled only on the wrap read.
- `out_buffer_weight`  out  `DATA_WIDTH`  weight read from the bank; registered.
- `valid_out`  out  1  one-cycle pulse marking a fresh `out_buffer_weight`.
- `last_out`  out  1  pulse with `valid_out` when the word read is index `DEPTH`-1.
- `weights_ready`  out  1  bank holds a complete set (READY state).
- `overflow`  out  1  sticky; a write arrived while the bank was full.

## Operation
- Input stage: `valid_in` and `in` are registered once (`in_q`, `vin_q`) before the write.
- FSM with two states: FILL and READY. Reset state is FILL.
- FILL state:
  - When `vin_q`=1, write `in_q` to mem[`wr_ptr`] and increment `wr_ptr`.
  - Writing index `DEPTH`-1 moves the FSM to READY and resets `wr_ptr` to 0.
  - `load_weights` is ignored: no `valid_out`, and `out_buffer_weight` holds its value.
- READY state:
  - `weights_ready`=1.
  - When `vin_q`=1, the write is dropped and `overflow` is set. `overflow` clears only on `reset`.
  - When `load_weights`=1, read mem[`rd_ptr`] into `out_buffer_weight` and pulse `valid_out`.
  - On that read, `rd_ptr` increments and wraps from `DEPTH`-1 to 0. A read at index `DEPTH`-1 also pulses `last_out`.
  - Wrap read with `replay_en`=1: the FSM stays READY and the content is reused.
  - Wrap read with `replay_en`=0: the FSM returns to FILL and `weights_ready` drops on the next cycle. Old content is overwritten by the next fill.
- No simultaneous write and read is possible; FILL only writes and READY only reads.
- Pointer arithmetic compares against `DEPTH`, not 2^`ADDR_WIDTH`, so non-power-of-two depths wrap correctly.
- Reset, including reset mid-fill or mid-read, clears the following:
  - `wr_ptr` and `rd_ptr` to 0.
  - FSM to FILL.
  - `vin_q`, `valid_out`, `last_out`, `weights_ready` and `overflow` to 0.
  - `out_buffer_weight` to 0.
- Reset does not clear the RAM contents. Those contents cannot be read until a full refill completes.

## Timing
- Reset values of all outputs are 0.
- Write latency:
  - A word presented with `valid_in` at edge E0 is captured by the input stage.
  - It is written to the RAM at edge E0+1.
- Ready latency: `weights_ready` is 1 in the cycle after the edge that writes the `DEPTH`-th word. That is 2 cycles after the last `valid_in` sample.
- Read latency:
  - `load_weights`=1 sampled at edge E gives `out_buffer_weight`, `valid_out` and `last_out` in the cycle after E.
  - Back-to-back requests give one word per cycle.
  - `valid_out` is a pulse, not a sticky level.
- Consume-mode wrap:
  - After the wrap read at edge E, `weights_ready`=0 from E onward.
  - A `load_weights` in the cycle after E is ignored.
  - A `valid_in` sampled at E is a FILL write at E+1 and is not counted as an overflow.
- `replay_en` is used only at the edge of the wrap read. Changing it at any other time has no effect.

## Test plan
- Fill and drain (`DEPTH`=4, `replay_en`=0):
  - Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles; `weights_ready` rises 2 cycles after the last one.
  - Hold `load_weights` for 4 cycles; outputs are 0x11..0x44 with `valid_out`=1 each cycle, `last_out`=1 only with 0x44.
  - `weights_ready`=0 afterwards.
- Replay (`replay_en`=1):
  - After one fill, issue 12 consecutive loads; the sequence 0x11..0x44 repeats three times.
  - `last_out` pulses 3 times and `weights_ready` stays 1.
- Early/overflow:
  - `load_weights` during FILL gives no `valid_out` and `out_buffer_weight` unchanged (0).
  - A fifth write while READY sets `overflow`=1 and does not alter the read data.
- Gapped traffic:
  - Apply random `valid_in` and `load_weights` bubbles.
  - The read order matches the write order, and the count of `valid_out` pulses equals the count of accepted loads.
- Reset mid-read:
  - Reset after 2 reads; all outputs are 0.
  - Refill with 0xA0..0xA3; the first read returns 0xA0.
- Non-power-of-two depth: with `DEPTH`=3 and `ADDR_WIDTH`=2, replay wraps 0→1→2→0 and never reads index 3.
